fetch: RTL and testbench

Instruction-fetch stage of the Beta pipeline, directly upstream of `decode`. It holds the program counter and issues single-outstanding requests to instruction memory over a req/ack handshake. It presents `inst` and `pc_plus_four` to decode through a pipeline register. It applies decode's redirect (branch, jump, exception vectors) and annuls the slot fetched under a redirect with a NOP.

---
 rtl/beta_pkg.sv | 28 ++
 rtl/pc_next.sv | 38 +++
 rtl/fetch.sv | 126 ++++++++++++
 tb/tb_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// beta_pkg -- shared Beta pipeline types: PC-select codes, vectors, fetch FSM states.
// Rev 1.0
`default_nettype none

package beta_pkg;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP_INST  = 32'hC3FF_0000;

  typedef enum logic [2:0] {
    PC_INC   = 3'd0,
    PC_BR    = 3'd1,
    PC_JMP   = 3'd2,
    PC_ILLOP = 3'd3,
    PC_XADR  = 3'd4
  } pc_sel_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next.sv
// pc_next -- combinational next-PC mux; keeps the supervisor bit out of user reach.
// Rev 1.0
`default_nettype none

module pc_next
  import beta_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_sel,
  input  logic [31:0] i_branch_addr,
  input  logic [31:0] i_jump_addr,
  output logic [31:0] o_target,
  output logic [31:0] o_pc_inc
);

  logic [31:0] w_inc;
  logic        w_unused;

  // Increment wraps inside the low 31 bits so the mode bit never flips.
  assign w_inc    = {i_pc[31], i_pc[30:0] + 31'd4};
  assign o_pc_inc = w_inc;

  assign w_unused = ^{i_branch_addr[31], i_branch_addr[1:0], i_jump_addr[1:0]};

  always_comb begin
    o_target = w_inc;
    case (i_sel)
      PC_BR:    o_target = {i_pc[31], i_branch_addr[30:2], 2'b00};
      PC_JMP:   o_target = {i_pc[31] & i_jump_addr[31], i_jump_addr[30:2], 2'b00};
      PC_ILLOP: o_target = ILLOP_VEC;
      PC_XADR:  o_target = XADR_VEC;
      default:  o_target = w_inc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// fetch -- Beta instruction-fetch stage: PC, single-outstanding imem handshake, skid, redirect annul.
// Rev 1.0
`default_nettype none

module fetch
  import beta_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc_plus_four,
  output logic        inst_valid
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_drain_addr;
  logic [31:0]  r_inst;
  logic [31:0]  r_pc4;
  logic         r_valid;
  logic [31:0]  r_skid_inst;
  logic [31:0]  r_skid_pc4;

  logic [31:0]  w_target;
  logic [31:0]  w_pc_inc;
  logic         w_redirect;

  pc_next u_pc_next (
    .i_pc          (r_pc),
    .i_sel         (pc_sel),
    .i_branch_addr (branch_addr),
    .i_jump_addr   (jump_addr),
    .o_target      (w_target),
    .o_pc_inc      (w_pc_inc)
  );

  // A redirect presented under stall is ignored; decode holds and re-presents it.
  assign w_redirect = !stall && (pc_sel != 3'(PC_INC)) && (pc_sel <= 3'(PC_XADR));

  assign imem_req     = !rst && (r_state != HOLD);
  assign imem_addr    = (r_state == DRAIN) ? r_drain_addr : r_pc;
  assign inst         = r_inst;
  assign pc_plus_four = r_pc4;
  assign inst_valid   = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_VEC;
      r_drain_addr <= RESET_VEC;
      r_inst       <= NOP_INST;
      r_pc4        <= RESET_VEC;
      r_valid      <= 1'b0;
      r_skid_inst  <= NOP_INST;
      r_skid_pc4   <= RESET_VEC;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_redirect) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
            r_pc    <= w_target;
            // Without an ack the request is still live at the old address.
            if (!imem_ack) begin
              r_drain_addr <= r_pc;
              r_state      <= DRAIN;
            end
          end else if (imem_ack && stall) begin
            r_skid_inst <= imem_rdata;
            r_skid_pc4  <= w_pc_inc;
            r_pc        <= w_pc_inc;
            r_state     <= HOLD;
          end else if (imem_ack) begin
            r_inst  <= imem_rdata;
            r_pc4   <= w_pc_inc;
            r_valid <= 1'b1;
            r_pc    <= w_pc_inc;
          end else if (!stall) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (w_redirect) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
            r_pc    <= w_target;
            r_state <= FETCH;
          end else if (!stall) begin
            r_inst  <= r_skid_inst;
            r_pc4   <= r_skid_pc4;
            r_valid <= 1'b1;
            r_state <= FETCH;
          end
        end

        DRAIN: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end
          if (!stall) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
          end
          if (imem_ack) begin
            r_state <= FETCH;
          end
        end

        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// tb_fetch -- directed + randomised bench for fetch against a queue-based behavioural model.
// Rev 1.0
`default_nettype none

module tb_fetch;
  import beta_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  pc_sel;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc_plus_four;
  logic        inst_valid;

  int n_checks = 0;
  int n_err    = 0;
  int lat      = 0;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  // Memory returns the word address as the instruction; ack after lat waiting cycles.
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr;

  fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_sel       (pc_sel),
    .branch_addr  (branch_addr),
    .jump_addr    (jump_addr),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .pc_plus_four (pc_plus_four),
    .inst_valid   (inst_valid)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] i;
    logic [31:0] p4;
  } skid_t;

  logic [31:0] m_pc, m_inst, m_pc4, m_stale_addr;
  logic        m_valid, m_stale;
  skid_t       m_skid[$];
  bit          m_live = 1'b0;

  function automatic logic [31:0] inc4(input logic [31:0] a);
    return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] target_of(input logic [2:0] sel, input logic [31:0] pc,
                                            input logic [31:0] ba, input logic [31:0] ja);
    case (sel)
      3'd1:    return (pc & 32'h8000_0000) | (ba & 32'h7FFF_FFFC);
      3'd2:    return (pc & ja & 32'h8000_0000) | (ja & 32'h7FFF_FFFC);
      3'd3:    return ILLOP_VEC;
      3'd4:    return XADR_VEC;
      default: return inc4(pc);
    endcase
  endfunction

  task automatic bubble();
    m_inst  = NOP_INST;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic [2:0] sel, input logic ack,
                            input logic [31:0] rd, input logic [31:0] ba, input logic [31:0] ja);
    logic        redir;
    logic [31:0] tgt;
    skid_t       e;
    if (r) begin
      m_pc = RESET_VEC; m_inst = NOP_INST; m_pc4 = RESET_VEC; m_valid = 1'b0;
      m_skid.delete(); m_stale = 1'b0; m_stale_addr = RESET_VEC;
      return;
    end
    redir = !s && (sel >= 3'd1) && (sel <= 3'd4);
    tgt   = target_of(sel, m_pc, ba, ja);
    if (m_skid.size() != 0) begin
      if (redir) begin
        m_skid.delete(); bubble(); m_pc = tgt;
      end else if (!s) begin
        e = m_skid.pop_front();
        m_inst = e.i; m_pc4 = e.p4; m_valid = 1'b1;
      end
    end else if (m_stale) begin
      if (redir) m_pc = tgt;
      if (!s) bubble();
      if (ack) m_stale = 1'b0;
    end else if (redir) begin
      bubble();
      if (!ack) begin
        m_stale = 1'b1; m_stale_addr = m_pc;
      end
      m_pc = tgt;
    end else if (ack) begin
      if (s) begin
        e.i = rd; e.p4 = inc4(m_pc);
        m_skid.push_back(e);
      end else begin
        m_inst = rd; m_pc4 = inc4(m_pc); m_valid = 1'b1;
      end
      m_pc = inc4(m_pc);
    end else if (!s) begin
      bubble();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, stall, pc_sel, imem_ack, imem_rdata, branch_addr, jump_addr);
      wait_cnt <= (rst || !imem_req || imem_ack) ? 0 : wait_cnt + 1;
      if (rst) m_live = 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic exp_req;
    forever begin
      @(negedge clk);
      if (m_live) begin
        exp_req = !rst && (m_skid.size() == 0);
        chk("m_inst", inst, m_inst);
        chk("m_pc4", pc_plus_four, m_pc4);
        chk("m_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("m_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("m_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] held;
    rst = 1'b1; stall = 1'b0; pc_sel = 3'd0; branch_addr = '0; jump_addr = '0; lat = 0;
    step(); step();
    chk("rst_inst", inst, NOP_INST);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc4", pc_plus_four, 32'h8000_0000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0; #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h8000_0000);

    step();
    chk("seq_addr1", imem_addr, 32'h8000_0004);
    chk("seq_inst0", inst, 32'h8000_0000);
    chk("seq_pc4_0", pc_plus_four, 32'h8000_0004);
    chk("seq_valid0", {31'd0, inst_valid}, 32'd1);
    step();
    chk("seq_addr2", imem_addr, 32'h8000_0008);
    chk("seq_inst1", inst, 32'h8000_0004);
    step(); step();
    chk("br_pc", imem_addr, 32'h8000_0010);

    pc_sel = 3'd1; branch_addr = 32'h0000_0100;
    step(); pc_sel = 3'd0;
    chk("br_addr", imem_addr, 32'h8000_0100);
    chk("br_annul", inst, NOP_INST);
    chk("br_annul_v", {31'd0, inst_valid}, 32'd0);
    step();
    chk("br_inst", inst, 32'h8000_0100);
    chk("br_inst_v", {31'd0, inst_valid}, 32'd1);

    pc_sel = 3'd2; jump_addr = 32'h0000_0040;
    step();
    chk("user_enter", imem_addr, 32'h0000_0040);
    jump_addr = 32'h8000_0200;
    step(); pc_sel = 3'd0;
    chk("user_jmp", imem_addr, 32'h0000_0200);

    held = inst;
    stall = 1'b1;
    step();
    chk("stall_req1", {31'd0, imem_req}, 32'd0);
    chk("stall_hold1", inst, held);
    step();
    chk("stall_req2", {31'd0, imem_req}, 32'd0);
    step();
    chk("stall_req3", {31'd0, imem_req}, 32'd0);
    chk("stall_hold3", inst, held);
    stall = 1'b0;
    step();
    chk("skid_inst", inst, 32'h0000_0200);
    chk("skid_valid", {31'd0, inst_valid}, 32'd1);
    chk("skid_next_addr", imem_addr, 32'h0000_0204);
    step();
    chk("after_skid", inst, 32'h0000_0204);

    lat = 1; pc_sel = 3'd3;
    step(); pc_sel = 3'd0;
    chk("drain_addr", imem_addr, 32'h0000_0208);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("illop_addr", imem_addr, 32'h8000_0004);
    step(); step();
    chk("illop_inst", inst, 32'h8000_0004);

    pc_sel = 3'd4;
    step(); pc_sel = 3'd0;
    chk("drain2_addr", imem_addr, 32'h8000_0008);
    rst = 1'b1;
    step();
    chk("drst_inst", inst, NOP_INST);
    chk("drst_valid", {31'd0, inst_valid}, 32'd0);
    chk("drst_pc4", pc_plus_four, 32'h8000_0000);
    rst = 1'b0; #1;
    chk("drst_addr", imem_addr, 32'h8000_0000);
    chk("drst_req", {31'd0, imem_req}, 32'd1);

    lat = 0; pc_sel = 3'd2; jump_addr = 32'hFFFF_FFFC;
    step(); pc_sel = 3'd0;
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr", imem_addr, 32'h8000_0000);
    chk("wrap_inst", inst, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus_four, 32'h8000_0000);

    for (int k = 0; k < 300; k++) begin
      stall       = ($urandom_range(0, 3) == 0);
      pc_sel      = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      branch_addr = $urandom();
      jump_addr   = $urandom();
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 2);
      rst         = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; stall = 1'b0; pc_sel = 3'd0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
